// File: rtl/fp_mul_norm_round.sv
// rtl/fp_mul_norm_round.sv - two-stage normalise/round(RNE)/pack of FP_Mul product to IEEE-754 single
// Optional status flags (flags_o-style outputs flags/flags_acc, input flags_clr) enabled by FP_MUL_NORM_FLAGS_EN.
module fp_mul_norm_round #(
    parameter int          EXP_W = 10,
    parameter logic [31:0] QNAN  = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [47:0]      in_prod,
    input  logic             in_nan,
    input  logic             in_inf,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef FP_MUL_NORM_FLAGS_EN
    output logic [2:0]       flags,
    output logic [2:0]       flags_acc,
    input  logic             flags_clr,
`endif
    output logic [31:0]      C
);
    localparam int XW = EXP_W + 1;

    logic                 en;
    logic                 s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic [23:0]          s1_mant_q, n_mant;
    logic                 s1_guard_q, s1_sticky_q, n_guard, n_sticky;
    logic signed [XW-1:0] s1_exp_q, n_exp, r_exp;
    logic                 out_valid_q;
    logic [31:0]          c_q, c_d;
    logic                 round_up, ovf, unf, inx;
    logic [24:0]          sum25;
    logic [23:0]          r_mant;

    assign en        = ~out_valid_q | out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign C         = c_q;

    always_comb begin
        n_exp = {in_exp[EXP_W-1], in_exp};
        if (in_prod[47]) begin
            n_mant   = in_prod[47:24];
            n_guard  = in_prod[23];
            n_sticky = |in_prod[22:0];
            n_exp    = n_exp + XW'(1);
        end else begin
            n_mant   = in_prod[46:23];
            n_guard  = in_prod[22];
            n_sticky = |in_prod[21:0];
        end
    end

    // A carry out of the rounding add can only come from an all-ones mantissa, so the result is exactly 1.0
    always_comb begin
        round_up = s1_guard_q & (s1_sticky_q | s1_mant_q[0]);
        sum25    = {1'b0, s1_mant_q} + {24'h0, round_up};
        r_mant   = sum25[24] ? 24'h800000 : sum25[23:0];
        r_exp    = sum25[24] ? s1_exp_q + XW'(1) : s1_exp_q;
        ovf      = 1'b0;
        unf      = 1'b0;
        inx      = 1'b0;
        if (s1_nan_q) begin
            c_d = QNAN;
        end else if (s1_inf_q) begin
            c_d = {s1_sign_q, 8'hFF, 23'h0};
        end else if (s1_zero_q) begin
            c_d = {s1_sign_q, 31'h0};
        end else if (r_exp >= $signed(XW'(255))) begin
            c_d = {s1_sign_q, 8'hFF, 23'h0};
            ovf = 1'b1;
            inx = 1'b1;
        end else if (r_exp <= $signed(XW'(0))) begin
            c_d = {s1_sign_q, 31'h0};
            unf = 1'b1;
            inx = 1'b1;
        end else begin
            c_d = {s1_sign_q, r_exp[7:0], r_mant[22:0]};
            inx = s1_guard_q | s1_sticky_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_mant_q   <= 24'h0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_exp_q    <= '0;
            out_valid_q <= 1'b0;
            c_q         <= 32'h0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            out_valid_q <= s1_valid_q;
            if (in_valid) begin
                s1_sign_q   <= in_sign;
                s1_nan_q    <= in_nan;
                s1_inf_q    <= in_inf;
                s1_zero_q   <= in_zero;
                s1_mant_q   <= n_mant;
                s1_guard_q  <= n_guard;
                s1_sticky_q <= n_sticky;
                s1_exp_q    <= n_exp;
            end
            if (s1_valid_q) begin
                c_q <= c_d;
            end
        end
    end

`ifdef FP_MUL_NORM_FLAGS_EN
    logic [2:0] flags_q, flags_acc_q;

    assign flags     = flags_q;
    assign flags_acc = flags_acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b0;
        end else if (en && s1_valid_q) begin
            flags_q <= {ovf, unf, inx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_acc_q <= 3'b0;
        end else if (flags_clr) begin
            flags_acc_q <= 3'b0;
        end else if (out_valid_q && out_ready) begin
            flags_acc_q <= flags_acc_q | flags_q;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = ovf ^ unf ^ inx;
`endif
endmodule
